xm23_fetch_unit: RTL and testbench



---
 rtl/xm23_pkg.sv | 16 +
 rtl/xm23_fetch_unit.sv | 120 ++++++++++++
 tb/tb_xm23_fetch_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xm23_pkg.sv
// rtl/xm23_pkg.sv - shared types and constants for the XM23 fetch stage
package xm23_pkg;

    localparam int XM23_WORD_W = 16;
    localparam logic [XM23_WORD_W-1:0] XM23_PC_INC = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/xm23_fetch_unit.sv
// rtl/xm23_fetch_unit.sv - XM23 instruction fetch: PC, memory read, decoder handshake
module xm23_fetch_unit
    import xm23_pkg::*;
#(
    parameter logic [XM23_WORD_W-1:0] RESET_PC    = 16'h0000,
    parameter int                     MEM_LATENCY = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   run,
    input  logic                   step,
    input  logic                   slp,
    input  logic                   bkpt_en,
    input  logic [XM23_WORD_W-1:0] bkpt_addr,
    input  logic                   pc_load,
    input  logic [XM23_WORD_W-1:0] pc_new,
    output logic [XM23_WORD_W-1:0] mem_addr,
    output logic                   mem_rd,
    input  logic [XM23_WORD_W-1:0] mem_rdata,
    output logic [XM23_WORD_W-1:0] ir,
    output logic [XM23_WORD_W-1:0] ir_pc,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [XM23_WORD_W-1:0] pc,
    output logic                   halted,
    output logic                   fault
);

    fetch_state_t state, state_nxt;
    logic [2:0] lat_cnt;
    logic       step_q;
    logic       run_q;
    logic       bkpt_pass;

    logic step_pulse, run_rise, bkpt_hit, load_ok, capture, halt_release;

    assign step_pulse   = step & ~step_q;
    assign run_rise     = run & ~run_q;
    assign bkpt_hit     = bkpt_en && (pc == bkpt_addr) && !bkpt_pass;
    // An odd redirect target cannot pull the unit out of FAULT.
    assign load_ok      = pc_load && !((state == ST_FAULT) && pc_new[0]);
    assign capture      = (state == ST_WAIT) && (lat_cnt == 3'd1) && !pc_load;
    assign halt_release = (state == ST_HALT) && (step_pulse || run_rise);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_ok) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (slp)                     state_nxt = ST_IDLE;
                    else if (pc[0])              state_nxt = ST_FAULT;
                    else if (bkpt_hit)           state_nxt = ST_HALT;
                    else if (run || step_pulse)  state_nxt = ST_REQ;
                end
                ST_REQ:   state_nxt = ST_WAIT;
                ST_WAIT:  if (lat_cnt == 3'd1) state_nxt = ST_HOLD;
                ST_HOLD:  if (ir_ready) state_nxt = ST_IDLE;
                ST_HALT:  if (halt_release) state_nxt = ST_IDLE;
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd   = (state == ST_REQ);
        ir_valid = (state == ST_HOLD);
        halted   = (state == ST_HALT);
        fault    = (state == ST_FAULT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            ir_pc     <= '0;
            mem_addr  <= '0;
            lat_cnt   <= '0;
            step_q    <= 1'b0;
            run_q     <= 1'b0;
            bkpt_pass <= 1'b0;
        end else begin
            step_q <= step;
            run_q  <= run;
            if ((state == ST_IDLE) && (state_nxt == ST_REQ)) begin
                mem_addr <= pc;
            end
            if (state == ST_REQ) begin
                lat_cnt <= 3'(MEM_LATENCY);
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (capture) begin
                ir        <= mem_rdata;
                ir_pc     <= pc;
                pc        <= pc + XM23_PC_INC;
                bkpt_pass <= 1'b0;
            end
            if (halt_release && !pc_load) begin
                bkpt_pass <= 1'b1;
            end
            // Redirect wins over the sequential increment.
            if (load_ok) begin
                pc        <= pc_new;
                bkpt_pass <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xm23_fetch_unit.sv
// tb/tb_xm23_fetch_unit.sv - self-checking bench for xm23_fetch_unit
module tb_xm23_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset, run, step, slp, bkpt_en, pc_load, ir_ready;
    logic [15:0] bkpt_addr, pc_new, mem_rdata;
    logic [15:0] mem_addr, ir, ir_pc, pc;
    logic        mem_rd, ir_valid, halted, fault;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    xm23_fetch_unit #(.RESET_PC(16'h0000), .MEM_LATENCY(1)) dut (
        .Clock(Clock), .Reset(Reset), .run(run), .step(step), .slp(slp),
        .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .pc_load(pc_load), .pc_new(pc_new),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .pc(pc), .halted(halted), .fault(fault)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        if (a == 16'h0000) return 16'h4C08;
        m = a * 16'h9E37;
        return m ^ 16'h1234;
    endfunction

    // Program memory with a one-cycle read latency.
    logic        pipe_v;
    logic [15:0] pipe_a;
    always @(posedge Clock) begin
        pipe_v <= mem_rd;
        pipe_a <= mem_addr;
    end
    assign mem_rdata = (pipe_v === 1'b1) ? mem_word(pipe_a) : 16'hBAD0;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1; run = 1'b0; step = 1'b0; slp = 1'b0; bkpt_en = 1'b0;
        bkpt_addr = 16'h0; pc_load = 1'b0; pc_new = 16'h0; ir_ready = 1'b0;
        tick;
        tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({pc, ir, ir_pc, mem_addr} !== 64'h0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h ir=%h ir_pc=%h mem_addr=%h, expected all 0",
                     pc, ir, ir_pc, mem_addr);
        end
        checks++;
        if ({mem_rd, ir_valid, halted, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: rd/valid/halted/fault=%b expected 0000",
                     {mem_rd, ir_valid, halted, fault});
        end
    endtask

    task automatic test_run_basic;
        do_reset;
        run = 1'b1;
        tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL run_first_req: mem_rd=%b mem_addr=%h expected 1/0000", mem_rd, mem_addr);
        end
        tick;
        checks++;
        if (ir_valid !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL run_wait: ir_valid=%b mem_rd=%b expected 0/0", ir_valid, mem_rd);
        end
        tick;
        checks++;
        if (ir !== 16'h4C08 || ir_pc !== 16'h0 || ir_valid !== 1'b1 || pc !== 16'h2) begin
            errors++;
            $display("FAIL run_capture: ir=%h ir_pc=%h valid=%b pc=%h expected 4c08/0000/1/0002",
                     ir, ir_pc, ir_valid, pc);
        end
        run = 1'b0;
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        checks++;
        if (ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_accept: ir_valid=%b expected 0", ir_valid);
        end
    endtask

    task automatic test_step;
        int reads;
        do_reset;
        ir_ready = 1'b1;
        step = 1'b1;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (mem_rd) reads++;
        end
        checks++;
        if (reads != 1) begin
            errors++;
            $display("FAIL step_hold_once: reads=%0d expected 1", reads);
        end
        step = 1'b0;
        tick;
        step = 1'b1;
        tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL step_second: mem_rd=%b mem_addr=%h expected 1/0002", mem_rd, mem_addr);
        end
        for (int i = 0; i < 4; i++) tick;
        checks++;
        if (ir_pc !== 16'h0002 || ir !== mem_word(16'h0002) || pc !== 16'h0004) begin
            errors++;
            $display("FAIL step_second_data: ir=%h ir_pc=%h pc=%h expected %h/0002/0004",
                     ir, ir_pc, pc, mem_word(16'h0002));
        end
        step = 1'b0;
    endtask

    task automatic test_bkpt;
        int  reads4;
        bit  found, seen6, got4;
        do_reset;
        bkpt_en = 1'b1; bkpt_addr = 16'h0004; run = 1'b1; ir_ready = 1'b1;
        reads4 = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (mem_rd && mem_addr == 16'h0004) reads4++;
            if (halted) found = 1;
        end
        checks++;
        if (!found || pc !== 16'h0004 || reads4 != 0) begin
            errors++;
            $display("FAIL bkpt_halt: halted=%b pc=%h reads_of_4=%0d expected 1/0004/0",
                     halted, pc, reads4);
        end
        tick;
        checks++;
        if (halted !== 1'b1 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL bkpt_stay: halted=%b mem_rd=%b expected 1/0", halted, mem_rd);
        end
        step = 1'b1;
        tick;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL bkpt_release: halted=%b expected 0", halted);
        end
        seen6 = 0; got4 = 0;
        for (int i = 0; i < 20; i++) begin
            if (ir_valid && ir_ready && ir_pc == 16'h0004 && ir == mem_word(16'h0004)) got4 = 1;
            tick;
            if (mem_rd && mem_addr == 16'h0004) reads4++;
            if (mem_rd && mem_addr == 16'h0006) seen6 = 1;
        end
        checks++;
        if (reads4 != 1 || !seen6 || !got4 || halted !== 1'b0) begin
            errors++;
            $display("FAIL bkpt_resume: reads_of_4=%0d seen6=%0d got4=%0d halted=%b expected 1/1/1/0",
                     reads4, seen6, got4, halted);
        end
        step = 1'b0;
        bkpt_en = 1'b0;
    endtask

    task automatic test_redirect_wait;
        do_reset;
        run = 1'b1;
        tick;
        tick;
        pc_load = 1'b1;
        pc_new = 16'h0100;
        tick;
        pc_load = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || pc !== 16'h0100 || ir !== 16'h0000) begin
            errors++;
            $display("FAIL redirect_abort: ir_valid=%b pc=%h ir=%h expected 0/0100/0000",
                     ir_valid, pc, ir);
        end
        tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL redirect_req: mem_rd=%b mem_addr=%h expected 1/0100", mem_rd, mem_addr);
        end
        tick;
        tick;
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0100 || ir !== mem_word(16'h0100)) begin
            errors++;
            $display("FAIL redirect_data: valid=%b ir_pc=%h ir=%h expected 1/0100/%h",
                     ir_valid, ir_pc, ir, mem_word(16'h0100));
        end
        run = 1'b0;
    endtask

    task automatic test_fault;
        int reads;
        do_reset;
        run = 1'b1;
        pc_load = 1'b1;
        pc_new = 16'h0101;
        tick;
        pc_load = 1'b0;
        tick;
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_enter: fault=%b expected 1", fault);
        end
        reads = 0;
        pc_load = 1'b1;
        pc_new = 16'h0103;
        for (int i = 0; i < 6; i++) begin
            tick;
            pc_load = 1'b0;
            if (mem_rd) reads++;
        end
        checks++;
        if (reads != 0 || fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_stay: reads=%0d fault=%b expected 0/1", reads, fault);
        end
        pc_load = 1'b1;
        pc_new = 16'h0200;
        tick;
        pc_load = 1'b0;
        checks++;
        if (fault !== 1'b0 || pc !== 16'h0200) begin
            errors++;
            $display("FAIL fault_exit: fault=%b pc=%h expected 0/0200", fault, pc);
        end
        tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin
            errors++;
            $display("FAIL fault_resume: mem_rd=%b mem_addr=%h expected 1/0200", mem_rd, mem_addr);
        end
        run = 1'b0;
    endtask

    task automatic test_wrap;
        bit stable;
        do_reset;
        run = 1'b1;
        pc_load = 1'b1;
        pc_new = 16'hFFFE;
        tick;
        pc_load = 1'b0;
        tick;
        tick;
        tick;
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            if (ir_valid !== 1'b1 || ir !== mem_word(16'hFFFE) || ir_pc !== 16'hFFFE) stable = 0;
            tick;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL wrap_hold: valid=%b ir=%h ir_pc=%h expected stable 1/%h/fffe",
                     ir_valid, ir, ir_pc, mem_word(16'hFFFE));
        end
        ir_ready = 1'b1;
        run = 1'b0;
        tick;
        ir_ready = 1'b0;
        checks++;
        if (pc !== 16'h0000 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h valid=%b expected 0000/0", pc, ir_valid);
        end
        run = 1'b1;
        tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_next_req: mem_rd=%b mem_addr=%h expected 1/0000", mem_rd, mem_addr);
        end
        run = 1'b0;
    endtask

    // Transaction-level model: every read and every accepted word must follow
    // the in-order address stream, restarted by each redirect.
    task automatic test_random;
        logic [15:0] exp_pc;
        int accepts, bad_rd, bad_acc;
        do_reset;
        exp_pc = 16'h0000;
        accepts = 0; bad_rd = 0; bad_acc = 0;
        for (int i = 0; i < 600; i++) begin
            tick;
            if (mem_rd && mem_addr !== exp_pc) begin
                bad_rd++;
                if (bad_rd < 4)
                    $display("FAIL rand_read_addr: mem_addr=%h expected %h", mem_addr, exp_pc);
            end
            run      = ($urandom % 4) != 0;
            step     = $urandom % 2;
            slp      = ($urandom % 8) == 0;
            ir_ready = $urandom % 2;
            pc_load  = ($urandom % 16) == 0;
            pc_new   = 16'($urandom) & 16'hFFFE;
            if (ir_valid && ir_ready) begin
                accepts++;
                if (ir_pc !== exp_pc || ir !== mem_word(exp_pc)) begin
                    bad_acc++;
                    if (bad_acc < 4)
                        $display("FAIL rand_accept: ir_pc=%h ir=%h expected %h/%h",
                                 ir_pc, ir, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 16'd2;
            end
            if (pc_load) exp_pc = pc_new;
        end
        checks++;
        if (bad_rd != 0) begin
            errors++;
            $display("FAIL rand_reads: bad=%0d expected 0", bad_rd);
        end
        checks++;
        if (bad_acc != 0) begin
            errors++;
            $display("FAIL rand_accepts: bad=%0d expected 0", bad_acc);
        end
        checks++;
        if (accepts < 20) begin
            errors++;
            $display("FAIL rand_progress: accepts=%0d expected >= 20", accepts);
        end
        run = 1'b0; step = 1'b0; slp = 1'b0; ir_ready = 1'b0; pc_load = 1'b0;
    endtask

    initial begin
        test_reset;
        test_run_basic;
        test_step;
        test_bkpt;
        test_redirect_wait;
        test_fault;
        test_wrap;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
